// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive-side blocks.
//   rxState_t           : receive frame controller states
//   baudSel_t           : baud-rate select codes (2400/4800/9600/19200)
//   OVERSAMPLE_DEFAULT  : baudTick pulses per bit period
//   DATA_BITS_DEFAULT   : data bits per character
//   baudRate()          : maps a select code to its nominal bit rate
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rxState_t;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baudSel_t;

  // Nominal line rate in bits per second for a select code, used by the
  // baud generator and by anyone computing divider values.
  function automatic int unsigned baudRate(input baudSel_t sel);
    int unsigned rate;
    rate = 2400;
    case (sel)
      BAUD_2400:  rate = 2400;
      BAUD_4800:  rate = 4800;
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      default:    rate = 2400;
    endcase
    return rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clock : system clock
//   rst   : asynchronous reset, active-high; both flops load RESET_VAL
//   din   : asynchronous input
//   dout  : synchronized output (two clocks of latency)
// Parameters:
//   RESET_VAL : value held by both flops during reset, chosen to match the
//               idle level of the line so reset release causes no edge.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Receive-side frame controller. Detects a start bit on the synchronized
// line, samples each data bit at mid-bit using the oversampling tick,
// optionally checks even parity, checks the stop bit and hands the
// character to the consumer through a one-entry valid/ready register.
// Ports:
//   clock      : system clock
//   rst        : asynchronous reset, active-high; aborts any frame
//   baudTick   : one-cycle pulse, OVERSAMPLE per bit period
//   rxIn       : raw serial line, idle high, asynchronous
//   dataOut    : received character, stable while dataValid is high
//   dataValid  : holding register full
//   dataReady  : consumer accepts when dataValid && dataReady
//   busy       : controller is not idle
//   frameErr   : one-cycle pulse, stop bit sampled low
//   parityErr  : one-cycle pulse, parity mismatch (parity build only)
//   overrunErr : one-cycle pulse, frame completed while register full
// Configuration macro:
//   RX_PARITY_EN : when defined, one even-parity bit is expected between the
//                  data and the stop bit; otherwise parityErr is tied low.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 baudTick,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  input  logic                 dataReady,
  output logic                 busy,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 overrunErr
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // START samples on the tick that would move tickCnt to OVERSAMPLE/2-1,
  // i.e. the tick seen while the counter still holds OVERSAMPLE/2-2.
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 2);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxS;
  logic                 rxPrev;
  rxState_t             state;
  rxState_t             stateNext;
  logic [TICK_W-1:0]    tickCnt;
  logic [BIT_W-1:0]     bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 sampleMid;
  logic                 sampleEnd;
  logic                 shiftEn;
  logic                 commit;
  logic                 stopLow;
  logic                 commitGood;
  logic                 regBlocked;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock (clock),
    .rst   (rst),
    .din   (rxIn),
    .dout  (rxS)
  );

  assign sampleMid  = baudTick && (tickCnt == TICK_MID);
  assign sampleEnd  = baudTick && (tickCnt == TICK_END);
  assign busy       = (state != IDLE);
  assign regBlocked = dataValid && !dataReady;

  // Previous synchronized line level, reset high so that reset release on an
  // idle line is never mistaken for a start edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rxPrev <= 1'b1;
    end else begin
      rxPrev <= rxS;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and the per-cycle strobes that the datapath acts on.
  always_comb begin
    stateNext = state;
    shiftEn   = 1'b0;
    commit    = 1'b0;
    stopLow   = 1'b0;
    case (state)
      IDLE: begin
        if (rxPrev && !rxS) begin
          stateNext = START;
        end
      end
      START: begin
        if (sampleMid) begin
          stateNext = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sampleEnd) begin
          shiftEn = 1'b1;
          if (bitCnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (sampleEnd) begin
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (sampleEnd) begin
          if (rxS) begin
            commit    = 1'b1;
            stateNext = IDLE;
          end else begin
            stopLow   = 1'b1;
            stateNext = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxS) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Oversampling counter. Any state change restarts it at zero, so a tick in
  // the transition cycle is absorbed as the new state's first (zero) count.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tickCnt <= '0;
    end else if (stateNext != state) begin
      tickCnt <= '0;
    end else if (baudTick) begin
      tickCnt <= (tickCnt == TICK_END) ? '0 : tickCnt + 1'b1;
    end
  end

  // Data bit counter and shift register. Bits arrive LSB first, so each new
  // bit enters at the MSB and the first one ends up in bit 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      if (state != DATA && stateNext == DATA) begin
        bitCnt <= '0;
      end else if (shiftEn) begin
        bitCnt <= bitCnt + 1'b1;
      end
      if (shiftEn) begin
        if (DATA_BITS > 1) begin
          shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
        end else begin
          shiftReg <= rxS;
        end
      end
    end
  end

`ifdef RX_PARITY_EN
  logic parityFlag;

  // Parity flag is cleared at each new start edge and set when the received
  // parity bit disagrees with the even parity of the collected data.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      parityFlag <= 1'b0;
    end else if (state == IDLE && stateNext == START) begin
      parityFlag <= 1'b0;
    end else if (state == PARITY && sampleEnd && (rxS != (^shiftReg))) begin
      parityFlag <= 1'b1;
    end
  end

  // A frame with bad parity is reported at commit time and never delivered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      parityErr <= 1'b0;
    end else begin
      parityErr <= commit && parityFlag;
    end
  end

  assign commitGood = commit && !parityFlag;
`else
  assign parityErr  = 1'b0;
  assign commitGood = commit;
`endif

  // Holding register and the remaining error pulses. A commit while the
  // register is full and not being drained drops the new character; a commit
  // in the same cycle as a handshake simply replaces the drained one.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameErr   <= 1'b0;
      overrunErr <= 1'b0;
    end else begin
      frameErr   <= stopLow;
      overrunErr <= commitGood && regBlocked;
      if (commitGood && !regBlocked) begin
        dataOut   <= shiftReg;
        dataValid <= 1'b1;
      end else if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl (DATA_BITS=8, OVERSAMPLE=16,
// baudTick every 4 clocks unless running the free-tick case).
// A behavioural line decoder predicts the outputs; a compare process checks
// them every clock, and literal expectations pin the decoder.
// Honours RX_PARITY_EN for the parity frames.
module tb_uart_rx_frame_ctrl;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;

  logic       clock     = 1'b0;
  logic       rst       = 1'b1;
  logic       baudTick  = 1'b0;
  logic       rxIn      = 1'b1;
  logic       dataReady = 1'b1;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       busy;
  logic       frameErr;
  logic       parityErr;
  logic       overrunErr;

  int testsRun    = 0;
  int testsFailed = 0;

  int bitCycles = OVERSAMPLE * TICK_DIV;
  bit tickFree  = 1'b0;
  int tickPhase = 0;

`ifdef RX_PARITY_EN
  bit badParity = 1'b0;
`endif

  // model state
  logic       d1 = 1'b1, d2 = 1'b1, d3 = 1'b1;
  logic       busyNext = 1'b0;
  bit         commitPending = 1'b0, perrPending = 1'b0, ferrPending = 1'b0;
  logic [7:0] commitData = 8'h00;
  logic       expBusy = 1'b0, expValid = 1'b0, expFrame = 1'b0;
  logic       expParity = 1'b0, expOverrun = 1'b0;
  logic [7:0] expData = 8'h00;

  // pulse / edge monitors
  int   dvRise = 0, busyRise = 0, frameCnt = 0, parityCnt = 0, ovrCnt = 0;
  int   cyc = 0, fallCyc = -1, riseCyc = -1;
  bit   latArm = 1'b0;
  logic prevDv = 1'b0, prevBusy = 1'b0, prevRx = 1'b1;

  uart_rx_frame_ctrl #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .baudTick   (baudTick),
    .rxIn       (rxIn),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .busy       (busy),
    .frameErr   (frameErr),
    .parityErr  (parityErr),
    .overrunErr (overrunErr)
  );

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    #1;
    tickPhase = (tickPhase + 1) % TICK_DIV;
    baudTick  = tickFree ? 1'b1 : (tickPhase == 0);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Line as seen by the controller: rxIn delayed two clocks, plus one more
  // clock for the previous-level comparison.
  always @(posedge clock) begin
    if (rst) begin
      d1 = 1'b1; d2 = 1'b1; d3 = 1'b1;
    end else begin
      d3 = d2; d2 = d1; d1 = rxIn;
    end
  end

  task automatic waitTicks(input int n, output bit aborted);
    int t;
    t = 0;
    aborted = 1'b0;
    while (t < n) begin
      @(negedge clock);
      if (rst) begin
        aborted = 1'b1;
        return;
      end
      if (baudTick) t++;
    end
  endtask

  // Decode one frame from the detected start edge onward.
  task automatic runFrame();
    bit ab;
    logic [7:0] sh;
    bit perr;
    sh = 8'h00;
    perr = 1'b0;
    waitTicks(OVERSAMPLE / 2 - 1, ab);
    if (ab) return;
    if (d2) begin
      busyNext = 1'b0;
      return;
    end
    for (int i = 0; i < DATA_BITS; i++) begin
      waitTicks(OVERSAMPLE, ab);
      if (ab) return;
      sh[i] = d2;
    end
`ifdef RX_PARITY_EN
    waitTicks(OVERSAMPLE, ab);
    if (ab) return;
    perr = (d2 != (^sh));
`endif
    waitTicks(OVERSAMPLE, ab);
    if (ab) return;
    if (d2) begin
      busyNext = 1'b0;
      if (perr) perrPending = 1'b1;
      else begin
        commitPending = 1'b1;
        commitData    = sh;
      end
    end else begin
      ferrPending = 1'b1;
      forever begin
        @(negedge clock);
        if (rst) return;
        if (d2) begin
          busyNext = 1'b0;
          return;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (!rst && d3 && !d2) begin
      busyNext = 1'b1;
      runFrame();
    end
  end

  // Expected outputs for the next cycle, including the holding register.
  initial forever begin
    @(posedge clock);
    if (rst) begin
      expBusy = 1'b0; expValid = 1'b0; expData = 8'h00;
      expFrame = 1'b0; expParity = 1'b0; expOverrun = 1'b0;
      busyNext = 1'b0; commitPending = 1'b0; perrPending = 1'b0; ferrPending = 1'b0;
    end else begin
      expFrame   = ferrPending;
      expParity  = perrPending;
      expOverrun = 1'b0;
      if (commitPending) begin
        if (expValid && !dataReady) expOverrun = 1'b1;
        else begin
          expData  = commitData;
          expValid = 1'b1;
        end
      end else if (expValid && dataReady) begin
        expValid = 1'b0;
      end
      expBusy = busyNext;
      commitPending = 1'b0; perrPending = 1'b0; ferrPending = 1'b0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (!rst) begin
      checkOutput("cmp_busy",       busy,       expBusy);
      checkOutput("cmp_dataValid",  dataValid,  expValid);
      checkOutput("cmp_dataOut",    dataOut,    expData);
      checkOutput("cmp_frameErr",   frameErr,   expFrame);
      checkOutput("cmp_parityErr",  parityErr,  expParity);
      checkOutput("cmp_overrunErr", overrunErr, expOverrun);
    end
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (dataValid && !prevDv) dvRise++;
    if (busy && !prevBusy) busyRise++;
    if (frameErr) frameCnt++;
    if (parityErr) parityCnt++;
    if (overrunErr) ovrCnt++;
    if (latArm && !rxIn && prevRx) fallCyc = cyc;
    if (latArm && busy && !prevBusy) begin
      riseCyc = cyc;
      latArm  = 1'b0;
    end
    prevDv = dataValid; prevBusy = busy; prevRx = rxIn;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clock);
  endtask

  task automatic clearCounts();
    dvRise = 0; busyRise = 0; frameCnt = 0; parityCnt = 0; ovrCnt = 0;
  endtask

  task automatic sendBit(input logic b);
    rxIn = b;
    waitCycles(bitCycles);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) sendBit(data[i]);
`ifdef RX_PARITY_EN
    sendBit((^data) ^ badParity);
`endif
    sendBit(stopBit);
  endtask

  initial begin
    waitCycles(3);
    rst = 1'b0;
    sampleNow();
    checkOutput("reset_busy",       busy,       1'b0);
    checkOutput("reset_dataValid",  dataValid,  1'b0);
    checkOutput("reset_dataOut",    dataOut,    8'h00);
    checkOutput("reset_frameErr",   frameErr,   1'b0);
    checkOutput("reset_parityErr",  parityErr,  1'b0);
    checkOutput("reset_overrunErr", overrunErr, 1'b0);
    waitCycles(10);

    // clean 0xA5 frame, consumer always ready
    clearCounts();
    latArm = 1'b1;
    applyStimulus(8'hA5, 1'b1);
    sendBit(1'b1);
    checkOutput("a5_dvPulses",  dvRise, 1);
    checkOutput("a5_dataOut",   dataOut, 8'hA5);
    checkOutput("a5_errors",    frameCnt + parityCnt + ovrCnt, 0);
    checkOutput("a5_busyAfter", busy, 1'b0);
    checkOutput("a5_startLatency", riseCyc - fallCyc, 3);

    // 3-tick low glitch is rejected at the start midpoint
    clearCounts();
    rxIn = 1'b0;
    waitCycles(3 * TICK_DIV);
    rxIn = 1'b1;
    waitCycles(2 * bitCycles);
    checkOutput("glitch_busyRises", busyRise, 1);
    checkOutput("glitch_dvPulses",  dvRise, 0);
    checkOutput("glitch_errors",    frameCnt + parityCnt + ovrCnt, 0);
    checkOutput("glitch_busyAfter", busy, 1'b0);

    // 0x3C with a low stop bit, line then held low
    clearCounts();
    applyStimulus(8'h3C, 1'b0);
    waitCycles(2 * bitCycles);
    sampleNow();
    checkOutput("break_busyHeld", busy, 1'b1);
    checkOutput("break_frameErr", frameCnt, 1);
    checkOutput("break_dvPulses", dvRise, 0);
    rxIn = 1'b1;
    waitCycles(4);
    sampleNow();
    checkOutput("break_busyReleased", busy, 1'b0);
    sendBit(1'b1);

    // overrun: two characters with the consumer stalled
    clearCounts();
    dataReady = 1'b0;
    applyStimulus(8'h11, 1'b1);
    sendBit(1'b1);
    applyStimulus(8'h22, 1'b1);
    sendBit(1'b1);
    checkOutput("ovr_dataOut",   dataOut, 8'h11);
    checkOutput("ovr_dataValid", dataValid, 1'b1);
    checkOutput("ovr_pulses",    ovrCnt, 1);
    checkOutput("ovr_dvPulses",  dvRise, 1);
    dataReady = 1'b1;
    sampleNow();
    checkOutput("ovr_validAtAccept", dataValid, 1'b1);
    sampleNow();
    checkOutput("ovr_validCleared",  dataValid, 1'b0);
    waitCycles(2);

`ifdef RX_PARITY_EN
    clearCounts();
    badParity = 1'b1;
    applyStimulus(8'h07, 1'b1);
    sendBit(1'b1);
    checkOutput("par_bad_parityErr", parityCnt, 1);
    checkOutput("par_bad_dvPulses",  dvRise, 0);
    clearCounts();
    badParity = 1'b0;
    applyStimulus(8'h07, 1'b1);
    sendBit(1'b1);
    checkOutput("par_good_dataOut",   dataOut, 8'h07);
    checkOutput("par_good_dvPulses",  dvRise, 1);
    checkOutput("par_good_parityErr", parityCnt, 0);
`endif

    // reset in the middle of data bit 4 of 0xFF
    clearCounts();
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    rxIn = 1'b1;
    waitCycles(bitCycles / 2);
    rst = 1'b1;
    sampleNow();
    checkOutput("rst_busy",      busy,      1'b0);
    checkOutput("rst_dataValid", dataValid, 1'b0);
    checkOutput("rst_dataOut",   dataOut,   8'h00);
    checkOutput("rst_errors",    {29'd0, frameErr, parityErr, overrunErr}, 0);
    waitCycles(3);
    rst = 1'b0;
    sendBit(1'b1);
    clearCounts();
    applyStimulus(8'h5A, 1'b1);
    sendBit(1'b1);
    checkOutput("post_rst_dataOut",  dataOut, 8'h5A);
    checkOutput("post_rst_dvPulses", dvRise, 1);

    // baudTick held high continuously
    tickFree  = 1'b1;
    bitCycles = OVERSAMPLE;
    sendBit(1'b1);
    clearCounts();
    applyStimulus(8'hC3, 1'b1);
    sendBit(1'b1);
    checkOutput("free_dataOut",  dataOut, 8'hC3);
    checkOutput("free_dvPulses", dvRise, 1);
    checkOutput("free_errors",   frameCnt + parityCnt + ovrCnt, 0);

    waitCycles(4);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
